// File: rtl/multi_lane_collector_if.sv
// Bus bundle for multi_lane_collector: serial beat input, framing, and
// the valid/ack word output with error reporting.
interface multi_lane_collector_if #(
  parameter int LANES      = 1,
  parameter int WORD_WIDTH = 25
);
  logic [LANES-1:0]      serial_in;
  logic                  ready;
  logic                  data_ack;
  logic [WORD_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  frame_error;
  logic                  overrun;
  logic [7:0]            error_count;

  // master drives the serial stream and consumes words; slave is the collector
  modport master (
    output serial_in, ready, data_ack,
    input  data, data_valid, frame_error, overrun, error_count
  );
  modport slave (
    input  serial_in, ready, data_ack,
    output data, data_valid, frame_error, overrun, error_count
  );
endinterface

// File: rtl/multi_lane_collector.sv
// Multi-lane serial deserialiser with frame-length check and a valid/ack
// holding register so the consumer can stall without losing alignment.
module multi_lane_collector #(
  parameter int WORD_WIDTH = 25,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                 fast_clk,
  input  logic                 reset,
  multi_lane_collector_if.slave bus
);
  localparam int BEATS = WORD_WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 2);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] SAT_C   = CW'(BEATS + 1);

  if (WORD_WIDTH % LANES != 0) begin : g_bad_cfg
    $error("multi_lane_collector: WORD_WIDTH must be divisible by LANES");
  end

  logic [WORD_WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]         cnt;
  logic                  ready_q;
  logic                  frame_end, len_ok, commit, drop_ovr, drop_err;

  // A single-beat word is just the lane bus; otherwise shift by LANES.
  if (BEATS == 1) begin : g_one_beat
    assign sr_nxt = bus.serial_in;
  end else if (MSB_FIRST) begin : g_msb
    assign sr_nxt = {sr[WORD_WIDTH-LANES-1:0], bus.serial_in};
  end else begin : g_lsb
    assign sr_nxt = {bus.serial_in, sr[WORD_WIDTH-1:LANES]};
  end

  assign frame_end = bus.ready && !ready_q;
  assign len_ok    = (cnt == BEATS_C);
  assign commit    = frame_end && len_ok && (!bus.data_valid || bus.data_ack);
  assign drop_ovr  = frame_end && len_ok && bus.data_valid && !bus.data_ack;
  assign drop_err  = frame_end && !len_ok;

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      sr              <= '0;
      cnt             <= '0;
      ready_q         <= 1'b1;
      bus.data        <= '0;
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.error_count <= 8'd0;
    end else begin
      ready_q <= bus.ready;
      if (!bus.ready) begin
        sr <= sr_nxt;
        if (cnt != SAT_C) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (commit) begin
        bus.data       <= sr;
        bus.data_valid <= 1'b1;
      end else if (bus.data_ack) begin
        bus.data_valid <= 1'b0;
      end

      bus.frame_error <= drop_err;
      bus.overrun     <= drop_ovr;
      // Counted on the END edge so the count already includes the visible pulse.
      if ((drop_err || drop_ovr) && bus.error_count != 8'd255)
        bus.error_count <= bus.error_count + 8'd1;
    end
  end
endmodule

// File: doc/multi_lane_collector.md
# multi_lane_collector

Parametrised successor to the single-lane serial input collector. It deserialises a frame of WORD_WIDTH bits arriving on LANES parallel serial lanes, with a selectable bit order, and checks that each frame has the correct length. Completed words are presented through a valid/ack holding register, so a downstream consumer can stall without losing alignment. The block sits between the pad-side serial receivers and the core datapath, and pairs with the output emitter on the transmit side.

## Interface
- WORD_WIDTH, default 25: bits per deserialised word.
- LANES, default 1: number of serial lanes sampled per beat. WORD_WIDTH must be divisible by LANES; any other combination is an elaboration-time error.
- MSB_FIRST, default 0: bit order. 0 means the first beat carries the LSBs; 1 means the first beat carries the MSBs.
- Derived value BEATS = WORD_WIDTH/LANES.

Ports:
- fast_clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  LANES  serial data, one bit per lane per beat.
- ready  in  1  frame framing signal. Low means a beat is present this cycle. The first high cycle after a low run ends the frame.
- data_ack  in  1  consumer accepts the held word.
- data  out  WORD_WIDTH  most recently committed word.
- data_valid  out  1  data holds an unaccepted word.
- frame_error  out  1  one-cycle pulse: the frame ended with a beat count other than BEATS.
- overrun  out  1  one-cycle pulse: a good frame was dropped because the holding register was full.
- error_count  out  8  saturating count of frame_error plus overrun events.

## Operation
- Internal state: shift register sr[WORD_WIDTH-1:0]; beat counter cnt, which saturates at BEATS+1; registered previous value of ready, ready_q.
- SHIFT (ready sampled 0):
  - sr takes in serial_in.
  - cnt increments, saturating at BEATS+1.
- Shift direction:
  - MSB_FIRST=0: sr <= {serial_in, sr[W-1:LANES]}. Beat k, lane i ends at bit k*LANES+i.
  - MSB_FIRST=1: sr <= {sr[W-LANES-1:0], serial_in}. Beat k, lane i ends at bit W-LANES*(k+1)+i.
- END (ready sampled 1 with ready_q=0): the frame is evaluated, then cnt clears to 0.
  - cnt==BEATS and (data_valid==0 or data_ack==1): data <= sr, data_valid <= 1.
  - cnt==BEATS, data_valid==1 and data_ack==0: overrun pulses; data and data_valid are unchanged; the word is dropped.
  - cnt!=BEATS: frame_error pulses; the word is dropped; data and data_valid are affected only by data_ack.
- IDLE (ready sampled 1 with ready_q=1): no shifting; cnt held at 0.
- Handshake:
  - data_valid clears on an edge where data_ack=1, unless a commit happens on the same edge.
  - data_ack while data_valid=0 is ignored.
  - data is stable while data_valid=1.
- error_count increments by 1 on each frame_error or overrun pulse and saturates at 255. Only reset clears it.

## Timing
- Reset values:
  - data=0, data_valid=0, frame_error=0, overrun=0, error_count=0.
  - sr=0, cnt=0, ready_q=1.
- Reset takes effect immediately on assertion, including mid-frame; the partial frame is discarded.
- After reset is released, the first low-ready cycle is beat 0.
- Latency:
  - data/data_valid update on the same rising edge that first samples ready=1. This is 1 cycle after the last beat edge.
  - A frame occupies BEATS+1 cycles (BEATS beats plus 1 end cycle).
  - Back-to-back frames need only that single high cycle between low runs.
- frame_error and overrun are high for exactly the cycle following the END edge.
- A 1-cycle low run counts as 1 beat. Frames longer than BEATS+1 beats still report cnt=BEATS+1, which is an error.

## Test plan
- Defaults, 25 beats of 3461 LSB-first, then ready high -> data=3461 and data_valid=1 after that edge; both hold until data_ack; data_valid=0 on the edge after ack.
- WORD_WIDTH=24, LANES=4, MSB_FIRST=1, beats carrying nibbles A,B,C,D,E,F (lane i = nibble bit i) -> data=24'hABCDEF, data_valid=1, frame_error=0.
- Defaults: 24-beat frame -> frame_error pulses for 1 cycle, data_valid stays 0, error_count=1. Then a 27-beat frame -> frame_error again, error_count=2.
- Commit 69 with no ack, then a 25-beat frame of 25'h1FF_FFFF -> overrun pulse, data=69, error_count=1. Repeat with data_ack=1 on the END edge -> data=25'h1FF_FFFF, data_valid stays 1, no overrun.
- Assert reset after 10 beats -> all outputs 0 asynchronously. Release, then send a full 25-beat frame of 0 -> data_valid=1, data=0, frame_error=0.
- 300 consecutive 3-beat frames -> error_count saturates at 255 and stays there.
